// File: rtl/reservation_station_x2.sv
// Two-entry reservation station: holds decoded ops until both operands are ready, issues oldest first.
// Optional RS_FAST_WAKEUP_EN lets an entry issue in the same cycle as its final wakeup broadcast.
module reservation_station_x2 #(
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  decodeWriteEn_i,
  input  logic [ROBsizeLog-1:0] decodeROBTag_i,
  input  logic [ROBsizeLog-1:0] decodeROBTag1_i,
  input  logic [ROBsizeLog-1:0] decodeROBTag2_i,
  input  logic                  decodeReady1_i,
  input  logic                  decodeReady2_i,
  input  logic [63:0]           decodeROBval1_i,
  input  logic [63:0]           decodeROBval2_i,
  input  logic [9:0]            decodeCommands_i,
  output logic                  stall_o,
  input  logic [ROBsizeLog-1:0] issueROBTag_i,
  input  logic [64:0]           issueROBval_i,
  input  logic                  stall_i,
  output logic                  ready_o,
  output logic [63:0]           reservationStationVal1_o,
  output logic [63:0]           reservationStationVal2_o,
  output logic [9:0]            reservationStationCommands_o,
  output logic [ROBsizeLog-1:0] reservationStationTag_o
);

  logic [1:0]            valid, older, rdy1, rdy2;
  logic [ROBsizeLog-1:0] tag1 [2];
  logic [ROBsizeLog-1:0] tag2 [2];
  logic [ROBsizeLog-1:0] dstTag [2];
  logic [63:0]           val1 [2];
  logic [63:0]           val2 [2];
  logic [9:0]            cmd [2];

  logic        bcastValid;
  logic [63:0] bcastVal;
  logic [1:0]  match1, match2, eff1, eff2, issuable;
  logic        anySel, selIdx, issueFire, writeAcc, wIdx, oIdx;
  logic        decMatch1, decMatch2;

  assign bcastValid = issueROBval_i[64];
  assign bcastVal   = issueROBval_i[63:0];
  assign stall_o    = valid[0] & valid[1];
  assign writeAcc   = decodeWriteEn_i & ~stall_o;
  assign wIdx       = valid[0];
  assign oIdx       = ~wIdx;
  assign decMatch1  = bcastValid && (issueROBTag_i == decodeROBTag1_i);
  assign decMatch2  = bcastValid && (issueROBTag_i == decodeROBTag2_i);

  always_comb begin
    match1   = '0;
    match2   = '0;
    eff1     = '0;
    eff2     = '0;
    issuable = '0;
    for (int i = 0; i < 2; i++) begin
      match1[i] = bcastValid && (tag1[i] == issueROBTag_i);
      match2[i] = bcastValid && (tag2[i] == issueROBTag_i);
`ifdef RS_FAST_WAKEUP_EN
      eff1[i] = rdy1[i] | match1[i];
      eff2[i] = rdy2[i] | match2[i];
`else
      eff1[i] = rdy1[i];
      eff2[i] = rdy2[i];
`endif
      issuable[i] = valid[i] & eff1[i] & eff2[i];
    end
  end

  // With both issuable the age bit decides; a lone issuable entry is taken as is.
  always_comb begin
    anySel = |issuable;
    selIdx = 1'b0;
    if (issuable[0] && issuable[1]) selIdx = older[1];
    else if (issuable[1])           selIdx = 1'b1;
  end

  assign issueFire = anySel & ~stall_i;

  always_comb begin
    ready_o                      = 1'b0;
    reservationStationVal1_o     = '0;
    reservationStationVal2_o     = '0;
    reservationStationCommands_o = '0;
    reservationStationTag_o      = '0;
    if (anySel) begin
      ready_o                      = 1'b1;
      reservationStationVal1_o     = rdy1[selIdx] ? val1[selIdx] : bcastVal;
      reservationStationVal2_o     = rdy2[selIdx] ? val2[selIdx] : bcastVal;
      reservationStationCommands_o = cmd[selIdx];
      reservationStationTag_o      = dstTag[selIdx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid <= '0;
      older <= '0;
      rdy1  <= '0;
      rdy2  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (valid[i] && !rdy1[i] && match1[i]) begin
          rdy1[i] <= 1'b1;
          val1[i] <= bcastVal;
        end
        if (valid[i] && !rdy2[i] && match2[i]) begin
          rdy2[i] <= 1'b1;
          val2[i] <= bcastVal;
        end
      end
      if (issueFire) begin
        valid[selIdx] <= 1'b0;
        older[selIdx] <= 1'b0;
      end
      // The write slot was free before this edge, so it never collides with the issuing slot.
      if (writeAcc) begin
        valid[wIdx]  <= 1'b1;
        older[wIdx]  <= 1'b0;
        older[oIdx]  <= valid[oIdx] & ~(issueFire && (selIdx == oIdx));
        rdy1[wIdx]   <= decodeReady1_i | decMatch1;
        rdy2[wIdx]   <= decodeReady2_i | decMatch2;
        val1[wIdx]   <= decodeReady1_i ? decodeROBval1_i : bcastVal;
        val2[wIdx]   <= decodeReady2_i ? decodeROBval2_i : bcastVal;
        tag1[wIdx]   <= decodeROBTag1_i;
        tag2[wIdx]   <= decodeROBTag2_i;
        dstTag[wIdx] <= decodeROBTag_i;
        cmd[wIdx]    <= decodeCommands_i;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station_x2.sv
// Scoreboard bench for reservation_station_x2: stimulus pushes expected issues, a negedge monitor checks them.
module tb_reservation_station_x2;

  localparam int W = 6;
`ifdef RS_FAST_WAKEUP_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         decodeWriteEn_i;
  logic [W-1:0] decodeROBTag_i, decodeROBTag1_i, decodeROBTag2_i;
  logic         decodeReady1_i, decodeReady2_i;
  logic [63:0]  decodeROBval1_i, decodeROBval2_i;
  logic [9:0]   decodeCommands_i;
  logic         stall_o;
  logic [W-1:0] issueROBTag_i;
  logic [64:0]  issueROBval_i;
  logic         stall_i;
  logic         ready_o;
  logic [63:0]  reservationStationVal1_o, reservationStationVal2_o;
  logic [9:0]   reservationStationCommands_o;
  logic [W-1:0] reservationStationTag_o;

  reservation_station_x2 dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .decodeWriteEn_i(decodeWriteEn_i), .decodeROBTag_i(decodeROBTag_i),
    .decodeROBTag1_i(decodeROBTag1_i), .decodeROBTag2_i(decodeROBTag2_i),
    .decodeReady1_i(decodeReady1_i), .decodeReady2_i(decodeReady2_i),
    .decodeROBval1_i(decodeROBval1_i), .decodeROBval2_i(decodeROBval2_i),
    .decodeCommands_i(decodeCommands_i), .stall_o(stall_o),
    .issueROBTag_i(issueROBTag_i), .issueROBval_i(issueROBval_i),
    .stall_i(stall_i), .ready_o(ready_o),
    .reservationStationVal1_o(reservationStationVal1_o),
    .reservationStationVal2_o(reservationStationVal2_o),
    .reservationStationCommands_o(reservationStationCommands_o),
    .reservationStationTag_o(reservationStationTag_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] tag;
    logic [63:0]  v1;
    logic [63:0]  v2;
    logic [9:0]   cmd;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] tag, input logic [63:0] v1, input logic [63:0] v2,
                      input logic [9:0] cmd);
    exp_t e;
    e.tag = tag; e.v1 = v1; e.v2 = v2; e.cmd = cmd;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [W-1:0] tag, input logic r1, input logic [W-1:0] t1,
                    input logic [63:0] v1, input logic r2, input logic [W-1:0] t2,
                    input logic [63:0] v2, input logic [9:0] cmd);
    decodeWriteEn_i  = 1'b1;
    decodeROBTag_i   = tag;
    decodeReady1_i   = r1;
    decodeROBTag1_i  = t1;
    decodeROBval1_i  = v1;
    decodeReady2_i   = r2;
    decodeROBTag2_i  = t2;
    decodeROBval2_i  = v2;
    decodeCommands_i = cmd;
  endtask

  task automatic bc(input logic [W-1:0] tag, input logic [63:0] val);
    issueROBTag_i = tag;
    issueROBval_i = {1'b1, val};
  endtask

  // Advance one cycle; per-cycle pulses (write, broadcast) default back to idle.
  task automatic tick();
    @(posedge clk_i);
    #1;
    decodeWriteEn_i = 1'b0;
    issueROBval_i   = '0;
    issueROBTag_i   = '0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (ready_o && !stall_i) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_issue: got tag %0d expected no issue", reservationStationTag_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("issue_tag", 64'(reservationStationTag_o), 64'(e.tag));
          chk("issue_val1", reservationStationVal1_o, e.v1);
          chk("issue_val2", reservationStationVal2_o, e.v2);
          chk("issue_cmd", 64'(reservationStationCommands_o), 64'(e.cmd));
        end
      end else if (!ready_o) begin
        chk("idle_outputs_zero", reservationStationVal1_o | reservationStationVal2_o |
            64'(reservationStationCommands_o) | 64'(reservationStationTag_o), 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1; stall_i = 1'b0;
    decodeWriteEn_i = 0; decodeROBTag_i = 0; decodeROBTag1_i = 0; decodeROBTag2_i = 0;
    decodeReady1_i = 0; decodeReady2_i = 0; decodeROBval1_i = 0; decodeROBval2_i = 0;
    decodeCommands_i = 0; issueROBTag_i = 0; issueROBval_i = 0;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    tick();

    // Both operands ready at decode: presented the cycle after the write edge, then freed.
    wr(5, 1, 0, 64'h10, 1, 0, 64'h20, 10'h001);
    push(5, 64'h10, 64'h20, 10'h001);
    @(negedge clk_i); chk("t1_write_cycle", 64'(ready_o), 64'd0);
    tick();
    @(negedge clk_i); chk("t1_ready", 64'(ready_o), 64'd1);
    tick();
    @(negedge clk_i); chk("t1_freed", 64'(ready_o), 64'd0);
    tick();

    // Operand 1 waits on tag 3; broadcast 0xABCD in cycle N.
    wr(7, 0, 3, 64'h0, 1, 0, 64'h2, 10'h002);
    push(7, 64'hABCD, 64'h2, 10'h002);
    tick();
    bc(3, 64'hABCD);
    @(negedge clk_i); chk("t2_cycle_n", 64'(ready_o), 64'(FAST));
    tick();
    @(negedge clk_i); chk("t2_cycle_n1", 64'(ready_o), 64'(!FAST));
    tick();

    // Fill under stall, third write ignored, hold for several cycles, oldest-first issue.
    stall_i = 1'b1;
    wr(10, 1, 0, 64'h100, 1, 0, 64'h101, 10'h00A);
    push(10, 64'h100, 64'h101, 10'h00A);
    tick();
    wr(11, 1, 0, 64'h110, 1, 0, 64'h111, 10'h00B);
    push(11, 64'h110, 64'h111, 10'h00B);
    @(negedge clk_i); chk("t3_not_full", 64'(stall_o), 64'd0);
    chk("t3_hold1_tag", 64'(reservationStationTag_o), 64'd10);
    tick();
    wr(9, 1, 0, 64'h900, 1, 0, 64'h901, 10'h009);
    @(negedge clk_i); chk("t3_full", 64'(stall_o), 64'd1);
    chk("t3_hold2_tag", 64'(reservationStationTag_o), 64'd10);
    chk("t3_hold2_val1", reservationStationVal1_o, 64'h100);
    tick();
    @(negedge clk_i); chk("t3_hold3_tag", 64'(reservationStationTag_o), 64'd10);
    chk("t3_hold3_val2", reservationStationVal2_o, 64'h101);
    tick();
    stall_i = 1'b0;
    @(negedge clk_i); chk("t3_release_tag", 64'(reservationStationTag_o), 64'd10);
    tick();
    // New write lands in slot 0 but is younger than the survivor in slot 1.
    stall_i = 1'b1;
    wr(12, 1, 0, 64'h120, 1, 0, 64'h121, 10'h00C);
    push(12, 64'h120, 64'h121, 10'h00C);
    @(negedge clk_i); chk("t3_after_issue_stall", 64'(stall_o), 64'd0);
    tick();
    @(negedge clk_i); chk("t3_full_again", 64'(stall_o), 64'd1);
    chk("t3_oldest_tag", 64'(reservationStationTag_o), 64'd11);
    tick();
    stall_i = 1'b0;
    drain("t3_drain");

    // Decode-time capture of operand 2 from a coincident broadcast.
    wr(13, 1, 0, 64'h1, 0, 4, 64'h0, 10'h00D);
    bc(4, 64'h55);
    push(13, 64'h1, 64'h55, 10'h00D);
    tick();
    @(negedge clk_i); chk("t4_bypass_ready", 64'(ready_o), 64'd1);
    tick();
    drain("t4_drain");

    // One broadcast wakes both entries; older issues first.
    wr(22, 0, 8, 64'h0, 1, 0, 64'h3, 10'h016);
    push(22, 64'h88, 64'h3, 10'h016);
    tick();
    wr(23, 1, 0, 64'h4, 0, 8, 64'h0, 10'h017);
    push(23, 64'h4, 64'h88, 10'h017);
    tick();
    @(negedge clk_i); chk("t5_waiting", 64'(ready_o), 64'd0);
    bc(8, 64'h88);
    tick();
    drain("t5_drain");

    // Reset mid-operation discards both waiting entries.
    wr(20, 0, 6, 64'h0, 1, 0, 64'h7, 10'h014);
    tick();
    wr(21, 0, 6, 64'h0, 1, 0, 64'h8, 10'h015);
    tick();
    @(negedge clk_i); chk("t6_full", 64'(stall_o), 64'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    @(negedge clk_i); chk("t6_rst_ready", 64'(ready_o), 64'd0);
    chk("t6_rst_stall", 64'(stall_o), 64'd0);
    bc(6, 64'h66);
    tick();
    @(negedge clk_i); chk("t6_no_wake", 64'(ready_o), 64'd0);
    repeat (3) tick();

    chk("final_queue_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reservation_station_x2.md
Name: reservation_station_x2

Overview:
- Two-entry reservation station between the decode stage and one execution unit (ALU or divider) in the out-of-order datapath.
- Holds decoded instructions until both source operands are available.
- Operands that are not yet available are captured from the completion-stage broadcast bus.
- Presents the oldest ready entry to the execution unit under a ready/stall handshake.
- One instance per execution unit; four instances in the datapath.

Parameters:
ROBsize, 32, number of ROB entries
ROBsizeLog, $clog2(ROBsize+1), ROB tag width (6 at default)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
decodeWriteEn_i  in  1  decode writes a new instruction this cycle
decodeROBTag_i  in  ROBsizeLog  destination ROB tag of the new instruction
decodeROBTag1_i  in  ROBsizeLog  producer tag of operand 1 (meaningful only when not ready)
decodeROBTag2_i  in  ROBsizeLog  producer tag of operand 2
decodeReady1_i  in  1  operand 1 value is valid at decode
decodeReady2_i  in  1  operand 2 value is valid at decode
decodeROBval1_i  in  64  operand 1 value
decodeROBval2_i  in  64  operand 2 value
decodeCommands_i  in  10  control bits, carried through unchanged
stall_o  out  1  both entries occupied; decode must hold
issueROBTag_i  in  ROBsizeLog  completion broadcast tag
issueROBval_i  in  65  [64] broadcast valid, [63:0] result value
stall_i  in  1  execution unit cannot accept this cycle
ready_o  out  1  an issuable instruction is presented
reservationStationVal1_o  out  64  operand 1 of the presented instruction
reservationStationVal2_o  out  64  operand 2 of the presented instruction
reservationStationCommands_o  out  10  commands of the presented instruction
reservationStationTag_o  out  ROBsizeLog  destination tag of the presented instruction

Behaviour:
- Per-entry state: valid, age bit, rdy1, rdy2, tag1, tag2, val1, val2, commands, destination tag.
- Reset (synchronous): all entries invalid, rdy/age cleared. ready_o=0, stall_o=0, all data outputs 0.
- stall_o = entry0.valid & entry1.valid. It is driven from state only, with no path from stall_i.
- Write acceptance:
  - A write is accepted when decodeWriteEn_i=1 and stall_o=0; otherwise it is ignored.
  - The write goes to the lowest-index free entry. That entry becomes the youngest, and the other valid entry becomes the oldest.
- Decode capture bypass (always present): if an operand is not ready at decode and issueROBval_i[64]=1 with issueROBTag_i equal to its tag in the same cycle, the entry is written with that operand ready and holding issueROBval_i[63:0].
- Wakeup:
  - Every cycle, each valid entry with rdyN=0 compares tagN against a valid broadcast.
  - On a match, valN is loaded and rdyN=1 at the next edge.
  - Both operands may wake on the same broadcast.
- Selection and issue:
  - An entry is issuable when valid & rdy1 & rdy2.
  - If both entries are issuable, the oldest is selected.
  - ready_o=1 whenever an entry is selected. Outputs are combinational from the selected entry, and are 0 when ready_o=0.
  - Issue occurs at the edge where ready_o=1 and stall_i=0. The selected entry is invalidated at that edge.
  - While stall_i=1, the selected entry and its outputs stay stable. A different entry must not be substituted unless it is older.
- Simultaneous events:
  - Issue and write in the same cycle while full: the write is ignored, because stall_o was already 1.
  - Issue and write while not full: both happen. The written entry may reuse a slot freed that same edge only if it was the lowest-index free slot before the edge. Otherwise it takes the other slot.
  - A broadcast matching a tag in both entries wakes both.
- Latency:
  - A write with both operands ready at edge E gives ready_o=1 in the cycle after E.
  - A wakeup broadcast in cycle N gives ready_o=1 in cycle N+1; see Optional Feature.
- Reset asserted mid-operation discards all entries at the next edge. No issue occurs in the reset cycle.

Optional Feature:
RS_FAST_WAKEUP_EN
- Defined:
  - Selection also considers an entry issuable in the same cycle as the broadcast that makes its last missing operand ready.
  - The corresponding output takes issueROBval_i[63:0] combinationally.
  - If it issues that cycle (stall_i=0), the entry is freed without ever registering the value.
  - Oldest-first priority is unchanged.
- Undefined: wakeup becomes visible only in the following cycle (N+1 latency).

Test Plan:
- Reset, then write tag=5 with both operands ready (val1=0x10, val2=0x20), stall_i=0 -> next cycle ready_o=1, Val1=0x10, Val2=0x20, Tag=5; entry freed the following cycle and ready_o=0.
- Write tag=7 with op1 waiting on tag 3, then broadcast tag=3, val=0xABCD in cycle N -> ready_o=1 in N+1 (in N with RS_FAST_WAKEUP_EN) and Val1=0xABCD.
- Write two instructions with stall_i=1 -> stall_o=1, and a third write (tag=9) is ignored. Release stall_i -> the older instruction issues first, then the younger.
- Write with op2 tag=4 in the same cycle as broadcast tag=4, val=0x55 -> entry holds op2=0x55 and issues without any further broadcast.
- Entry held under stall_i=1 for 3 cycles -> outputs unchanged every cycle; issues on the first cycle stall_i=0.
- Both entries valid and waiting; assert reset_i -> next cycle ready_o=0, stall_o=0; a later broadcast matching the old tags has no effect.
